// File: rtl/pc_fetch_gen.sv
// Instruction-fetch address generator: issues sequential fetches over a
// req/gnt/rvalid bus, tags in-order responses with their PC and handles
// jump/interrupt redirects by discarding stale in-flight responses.
module pc_fetch_gen #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           INST_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR      = '0,
  parameter int unsigned           STEP            = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  int_flag_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  input  logic                  hold_flag_i,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [INST_WIDTH-1:0] rdata_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic                  run_q;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH-1:0] pc_fifo [MAX_OUTSTANDING];

  logic                  redir;
  logic [ADDR_WIDTH-1:0] target;
  logic                  accept;
  logic                  pop;
  logic                  deliver;

  // Ring-buffer pointer advance for a depth that need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Request qualification and handshake decode
  always_comb begin
    redir  = jump_flag_i | int_flag_i;
    target = jump_flag_i ? jump_addr_i : int_addr_i;
    req_o  = run_q & ~hold_flag_i & ~redir & (outstanding_q < MAX_CNT);
    addr_o = fetch_addr_q;
    accept = req_o & gnt_i;
    pop    = rvalid_i & (outstanding_q != '0);
  end

  // Next fetch address, in-flight count and discard count
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(pop);
    discard_d     = discard_q;
    deliver       = 1'b0;
    if (redir) begin
      // Everything still in flight after this cycle belongs to the old stream
      fetch_addr_d = target;
      discard_d    = outstanding_q - CNT_W'(pop);
    end else begin
      if (accept) begin
        fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(STEP);
      end
      if (pop) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          deliver = 1'b1;
        end
      end
    end
  end

  // Control state and registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q         <= 1'b0;
      fetch_addr_q  <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inst_valid_o  <= 1'b0;
      inst_o        <= '0;
      inst_pc_o     <= '0;
    end else begin
      run_q         <= 1'b1;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (accept) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      inst_valid_o <= deliver;
      if (deliver) begin
        inst_o    <= rdata_i;
        inst_pc_o <= pc_fifo[rd_ptr_q];
      end
    end
  end

  // PC FIFO storage; occupancy is tracked by the pointers and the counter
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_fifo[wr_ptr_q] <= addr_o;
    end
  end

endmodule
